// File: rtl/channel_4_pkg.sv
// rtl/channel_4_pkg.sv - shared command layout, FSM encoding and default tables for the noise channel controller
package channel_4_pkg;

  // Command word layout
  localparam int CMD_W       = 24;
  localparam int IDX_LSB     = 0;
  localparam int IDX_W       = 4;
  localparam int VOL_LSB     = 4;
  localparam int VOL_W       = 4;
  localparam int DECAY_LSB   = 8;
  localparam int DECAY_W     = 4;
  localparam int LEN_LSB     = 12;
  localparam int LEN_W       = 8;
  localparam int SHORT_BIT   = 20;
  localparam int CMD_USED_W  = SHORT_BIT + 1;

  localparam int ENV_W             = 9;
  localparam int ENV_SCALE_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_PLAY  = 2'd3
  } state_t;

  // Phase increment per noise period index, longest period last
  localparam logic [31:0] NOISE_PERIOD_DELTA [16] = '{
    32'h4000_0000, 32'h2000_0000, 32'h1555_5555, 32'h1000_0000,
    32'h0CCC_CCCD, 32'h0AAA_AAAB, 32'h0800_0000, 32'h0555_5555,
    32'h0400_0000, 32'h0200_0000, 32'h0100_0000, 32'h0080_0000,
    32'h0040_0000, 32'h0020_0000, 32'h0010_0000, 32'h0008_0000
  };

endpackage

// File: rtl/channel_4_noise_controller_envelope.sv
// rtl/channel_4_noise_controller_envelope.sv - volume decay, length counter and registered envelope
//   clk, rst_n       : clock, async active-low reset
//   load             : take volume/decay/length for a new note (wins over tick)
//   tick             : frame tick, ignored while no note is active
//   volume_in, decay_in, length_in : fields of the note being loaded
//   active           : note sounding
//   envelope         : registered volume*ENV_SCALE, 0 when not active
//   expire           : combinational, this tick ends the note
module noise_envelope_unit
  import channel_4_pkg::*;
#(
  parameter int ENV_SCALE = ENV_SCALE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               tick,
  input  logic [VOL_W-1:0]   volume_in,
  input  logic [DECAY_W-1:0] decay_in,
  input  logic [LEN_W-1:0]   length_in,
  output logic               active,
  output logic [ENV_W-1:0]   envelope,
  output logic               expire
);

  logic [VOL_W-1:0]   volume, volume_nx;
  logic [DECAY_W-1:0] decay_per, decay_per_nx;
  logic [DECAY_W-1:0] decay_cnt, decay_cnt_nx;
  logic [LEN_W-1:0]   length_cnt, length_cnt_nx;
  logic               active_nx;
  logic [ENV_W-1:0]   envelope_nx;

  // Length and decay both look at pre-tick values. Volume steps down on
  // the tick that takes the decay counter to zero, so a period of P drops
  // the volume on ticks P, 2P, 3P...
  always_comb begin
    volume_nx     = volume;
    decay_per_nx  = decay_per;
    decay_cnt_nx  = decay_cnt;
    length_cnt_nx = length_cnt;
    active_nx     = active;
    expire        = 1'b0;
    if (load) begin
      volume_nx     = volume_in;
      decay_per_nx  = decay_in;
      decay_cnt_nx  = decay_in;
      length_cnt_nx = length_in;
      active_nx     = 1'b1;
    end else if (tick && active) begin
      if (length_cnt != '0) begin
        length_cnt_nx = length_cnt - 1'b1;
        if (length_cnt == LEN_W'(1)) begin
          active_nx = 1'b0;
          expire    = 1'b1;
        end
      end
      if (decay_per != '0) begin
        if (decay_cnt <= DECAY_W'(1)) begin
          decay_cnt_nx = decay_per;
          if (volume != '0) volume_nx = volume - 1'b1;
        end else begin
          decay_cnt_nx = decay_cnt - 1'b1;
        end
      end
    end
    envelope_nx = active_nx ? ENV_W'(32'(volume_nx) * ENV_SCALE) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      volume     <= '0;
      decay_per  <= '0;
      decay_cnt  <= '0;
      length_cnt <= '0;
      active     <= 1'b0;
      envelope   <= '0;
    end else begin
      volume     <= volume_nx;
      decay_per  <= decay_per_nx;
      decay_cnt  <= decay_cnt_nx;
      length_cnt <= length_cnt_nx;
      active     <= active_nx;
      envelope   <= envelope_nx;
    end
  end

endmodule

// File: rtl/channel_4_noise_controller.sv
// rtl/channel_4_noise_controller.sv - command-driven noise channel controller (fetch/load/play FSM, period lookup)
//   i_clk, i_rst_n        : clock, async active-low reset (released synchronously)
//   i_tick_stb            : frame tick for envelope decay and length
//   i_note_stb            : note boundary, requests next command
//   i_cmd_valid/o_cmd_ready, i_cmd_data : command handshake
//   o_phase_delta(_valid) : phase increment for the phase generator
//   o_envelope            : volume*ENV_SCALE, 0 when silent
//   o_short_mode          : short LFSR tap select
//   o_active              : note sounding
//   o_underrun            : note boundary arrived while still waiting for a command
module channel_4_noise_controller
  import channel_4_pkg::*;
#(
  parameter int    ENV_SCALE         = ENV_SCALE_DEFAULT,
  parameter string PERIOD_TABLE_FILE = ""
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick_stb,
  input  logic             i_note_stb,
  input  logic             i_cmd_valid,
  input  logic [CMD_W-1:0] i_cmd_data,
  output logic             o_cmd_ready,
  output logic [31:0]      o_phase_delta,
  output logic             o_phase_delta_valid,
  output logic [ENV_W-1:0] o_envelope,
  output logic             o_short_mode,
  output logic             o_active,
  output logic             o_underrun
);

  if (15 * ENV_SCALE > 511) begin : g_bad_env_scale
    $error("ENV_SCALE must satisfy 15*ENV_SCALE <= 511");
  end
  if (PERIOD_TABLE_FILE != "") begin : g_no_table_file
    $error("PERIOD_TABLE_FILE loading is not available; leave it empty to use NOISE_PERIOD_DELTA");
  end

  // Reset asserts immediately, releases two clocks later on an edge
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t                state, state_nx;
  logic                  take_cmd;
  logic [CMD_USED_W-1:0] cmd_q;
  logic                  expire;
  logic                  cmd_rsvd_unused;

  assign cmd_rsvd_unused = ^i_cmd_data[CMD_W-1:CMD_USED_W];

  always_comb begin
    state_nx    = state;
    o_cmd_ready = 1'b0;
    take_cmd    = 1'b0;
    case (state)
      ST_IDLE:  if (i_note_stb) state_nx = ST_FETCH;
      ST_FETCH: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          take_cmd = 1'b1;
          state_nx = ST_LOAD;
        end
      end
      ST_LOAD:  state_nx = ST_PLAY;
      ST_PLAY: begin
        // A note boundary wins over expiry on the same tick
        if (i_note_stb)  state_nx = ST_FETCH;
        else if (expire) state_nx = ST_IDLE;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cmd_q         <= '0;
      o_phase_delta <= '0;
      o_short_mode  <= 1'b0;
      o_underrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      o_underrun <= (state == ST_FETCH) && i_note_stb;
      if (take_cmd) cmd_q <= i_cmd_data[CMD_USED_W-1:0];
      if (state == ST_LOAD) begin
        o_phase_delta <= NOISE_PERIOD_DELTA[cmd_q[IDX_LSB +: IDX_W]];
        o_short_mode  <= cmd_q[SHORT_BIT];
      end
    end
  end

  // Load priority inside the unit makes a tick during LOAD a no-op
  noise_envelope_unit #(
    .ENV_SCALE (ENV_SCALE)
  ) u_env (
    .clk       (i_clk),
    .rst_n     (rst_n),
    .load      (state == ST_LOAD),
    .tick      (i_tick_stb),
    .volume_in (cmd_q[VOL_LSB +: VOL_W]),
    .decay_in  (cmd_q[DECAY_LSB +: DECAY_W]),
    .length_in (cmd_q[LEN_LSB +: LEN_W]),
    .active    (o_active),
    .envelope  (o_envelope),
    .expire    (expire)
  );

  assign o_phase_delta_valid = o_active;

endmodule

// File: tb/tb_channel_4_noise_controller.sv
// tb/tb_channel_4_noise_controller.sv - self-checking bench for channel_4_noise_controller
module tb_channel_4_noise_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_stb = 1'b0;
  logic        note_stb = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [23:0] cmd_data = '0;
  logic        cmd_ready;
  logic [31:0] phase_delta;
  logic        phase_delta_valid;
  logic [8:0]  envelope;
  logic        short_mode;
  logic        active;
  logic        underrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  channel_4_noise_controller dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_tick_stb          (tick_stb),
    .i_note_stb          (note_stb),
    .i_cmd_valid         (cmd_valid),
    .i_cmd_data          (cmd_data),
    .o_cmd_ready         (cmd_ready),
    .o_phase_delta       (phase_delta),
    .o_phase_delta_valid (phase_delta_valid),
    .o_envelope          (envelope),
    .o_short_mode        (short_mode),
    .o_active            (active),
    .o_underrun          (underrun)
  );

  logic [31:0] tbl [16] = '{
    32'h4000_0000, 32'h2000_0000, 32'h1555_5555, 32'h1000_0000,
    32'h0CCC_CCCD, 32'h0AAA_AAAB, 32'h0800_0000, 32'h0555_5555,
    32'h0400_0000, 32'h0200_0000, 32'h0100_0000, 32'h0080_0000,
    32'h0040_0000, 32'h0020_0000, 32'h0010_0000, 32'h0008_0000
  };

  // Reference model: a note is described by its loaded fields plus the
  // number of ticks it has received; volume and liveness follow from that.
  typedef enum {M_IDLE, M_FETCH, M_LOAD, M_PLAY} mstate_t;
  mstate_t     m_st = M_IDLE;
  logic [23:0] m_cmd = '0;
  int          m_vol0 = 0, m_decay = 0, m_len = 0, m_ticks = 0;
  bit          m_active = 0, m_short = 0, m_underrun = 0;
  logic [31:0] m_delta = '0;

  function automatic int exp_env();
    int v;
    if (!m_active) return 0;
    v = m_vol0;
    if (m_decay != 0) v = (m_ticks / m_decay >= m_vol0) ? 0 : m_vol0 - m_ticks / m_decay;
    return v * 32;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_cmd = '0; m_vol0 = 0; m_decay = 0; m_len = 0; m_ticks = 0;
    m_active = 0; m_short = 0; m_underrun = 0; m_delta = '0;
  endtask

  task automatic model_step(input bit note, input bit tick, input bit valid, input logic [23:0] data);
    bit was_active;
    was_active = m_active;
    m_underrun = (m_st == M_FETCH) && note;
    if (tick && m_st != M_LOAD && m_active) begin
      m_ticks++;
      if (m_len != 0 && m_ticks >= m_len) m_active = 0;
    end
    case (m_st)
      M_IDLE:  if (note) m_st = M_FETCH;
      M_FETCH: if (valid) begin m_cmd = data; m_st = M_LOAD; end
      M_LOAD: begin
        m_vol0   = int'(m_cmd[7:4]);
        m_decay  = int'(m_cmd[11:8]);
        m_len    = int'(m_cmd[19:12]);
        m_short  = m_cmd[20];
        m_delta  = tbl[m_cmd[3:0]];
        m_ticks  = 0;
        m_active = 1;
        m_st     = M_PLAY;
      end
      M_PLAY: begin
        if (note) m_st = M_FETCH;
        else if (was_active && !m_active) m_st = M_IDLE;
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(m_st == M_FETCH));
    check({tag, ".phase_delta"}, phase_delta, m_delta);
    check({tag, ".pd_valid"}, 32'(phase_delta_valid), 32'(m_active));
    check({tag, ".envelope"}, 32'(envelope), 32'(exp_env()));
    check({tag, ".short_mode"}, 32'(short_mode), 32'(m_short));
    check({tag, ".active"}, 32'(active), 32'(m_active));
    check({tag, ".underrun"}, 32'(underrun), 32'(m_underrun));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 0);
    check({tag, ".phase_delta"}, phase_delta, 0);
    check({tag, ".pd_valid"}, 32'(phase_delta_valid), 0);
    check({tag, ".envelope"}, 32'(envelope), 0);
    check({tag, ".short_mode"}, 32'(short_mode), 0);
    check({tag, ".active"}, 32'(active), 0);
    check({tag, ".underrun"}, 32'(underrun), 0);
  endtask

  // Called at a negedge: drive, advance model, clock, compare at next negedge
  task automatic cyc(input string tag, input bit note, input bit tick, input bit valid, input logic [23:0] data);
    note_stb = note; tick_stb = tick; cmd_valid = valid; cmd_data = data;
    model_step(note, tick, valid, data);
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  function automatic logic [23:0] mk(int idx, int vol, int dec, int len, bit sh, int rsvd);
    logic [23:0] c;
    c = {3'(rsvd), sh, 8'(len), 4'(dec), 4'(vol), 4'(idx)};
    return c;
  endfunction

  task automatic start_note(input string tag, input logic [23:0] c);
    cyc(tag, 1, 0, 0, '0);
    cyc(tag, 0, 0, 1, c);
    cyc(tag, 0, 0, 0, '0);
  endtask

  initial begin
    int pulses;
    logic [23:0] c;

    // Power-up reset
    repeat (3) @(negedge clk);
    check_zero("por");
    rst_n = 1'b1;
    model_reset();
    repeat (4) cyc("idle_after_rst", 0, 0, 0, '0);

    // Basic load with reserved bits set, then 100 sustaining ticks
    start_note("basic", mk(3, 10, 0, 0, 1, 7));
    check("basic.delta_const", phase_delta, 32'h1000_0000);
    check("basic.env_const", 32'(envelope), 320);
    check("basic.short_const", 32'(short_mode), 1);
    check("basic.active_const", 32'(active), 1);
    for (int i = 0; i < 100; i++) cyc("basic_sustain", 0, 1, 0, '0);
    check("basic.env_after_100", 32'(envelope), 320);

    // Decay: vol 3, period 2
    start_note("decay", mk(5, 3, 2, 0, 0, 0));
    check("decay.env0", 32'(envelope), 96);
    for (int i = 1; i <= 8; i++) begin
      cyc("decay_tick", 0, 1, 0, '0);
      cyc("decay_gap", 0, 0, 0, '0);
      if (i == 2) check("decay.env_t2", 32'(envelope), 64);
      if (i == 4) check("decay.env_t4", 32'(envelope), 32);
      if (i == 6) check("decay.env_t6", 32'(envelope), 0);
    end
    check("decay.still_active", 32'(active), 1);

    // Length expiry: vol 15, len 4
    start_note("len", mk(9, 15, 0, 4, 0, 0));
    for (int i = 1; i <= 4; i++) begin
      cyc("len_tick", 0, 1, 0, '0);
      if (i == 3) check("len.env_t3", 32'(envelope), 480);
    end
    check("len.expired_active", 32'(active), 0);
    check("len.expired_env", 32'(envelope), 0);
    cyc("len_idle", 0, 0, 0, '0);

    // Underrun/backpressure with a decaying note behind it
    start_note("pre_under", mk(1, 12, 1, 0, 1, 0));
    pulses = 0;
    cyc("under_stb", 1, 0, 0, '0);
    for (int i = 0; i < 10; i++) begin
      cyc("under_wait", (i == 4), i[0], 0, '0);
      pulses += int'(underrun);
    end
    check("under.pulses", 32'(pulses), 1);
    cyc("under_take", 0, 0, 1, mk(7, 6, 0, 1, 0, 0));
    cyc("under_load", 0, 0, 0, '0);
    check("under.env_new", 32'(envelope), 192);

    // Simultaneous tick and note on a len=1 note
    cyc("simul", 1, 1, 0, '0);
    check("simul.env", 32'(envelope), 0);
    check("simul.ready", 32'(cmd_ready), 1);
    cyc("simul_take", 0, 0, 1, mk(0, 0, 0, 0, 0, 0));
    cyc("vol0_load", 0, 0, 0, '0);
    check("vol0.active", 32'(active), 1);
    check("vol0.env", 32'(envelope), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      c = 24'($urandom);
      c[19:12] = 8'($urandom_range(0, 6));
      c[11:8]  = 4'($urandom_range(0, 3));
      cyc("rand", ($urandom_range(0, 14) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 2) == 0), c);
    end

    // Async reset in the middle of a sounding note
    start_note("pre_rst", mk(12, 9, 0, 0, 1, 0));
    #2 rst_n = 1'b0;
    #1 check_zero("rst_async");
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("rst_hold");
    rst_n = 1'b1;
    repeat (4) cyc("idle_after_rst2", 0, 0, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
